// File: rtl/sample_sequencer.sv
// sample_sequencer: record/playback controller for the five-key sampler.
// Records one-hot notes into two step buffers (A, B), plays them back at a
// fixed step rate, and arbitrates live keys, A and B onto one note output.
//
// state | meaning
// ------+-----------------------------------------------------------
// LIVE  | note_out follows the valid live key; clear erases both tracks
// REC   | step_strobe appends the live note to the target track
// PLAY  | steps through the tracks, TICK_DIV cycles per step
// HOLD  | playback finished; note_out = 0, done = 1 until mode leaves 11
module sample_sequencer #(
    parameter int STEPS    = 8,
    parameter int NOTE_W   = 5,
    parameter int TICK_DIV = 12_500_000,
    localparam int SW = $clog2(STEPS),
    localparam int LW = SW + 1,
    localparam int TW = $clog2(TICK_DIV)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NOTE_W-1:0] keys,
    input  logic              step_strobe,
    input  logic [1:0]        mode,
    input  logic [1:0]        play_sel,
    input  logic              clear,
    output logic [NOTE_W-1:0] note_out,
    output logic [LW-1:0]     len_a,
    output logic [LW-1:0]     len_b,
    output logic [SW-1:0]     play_step,
    output logic              rec_full,
    output logic              done
);

    localparam logic [1:0] ST_LIVE = 2'd0;
    localparam logic [1:0] ST_REC  = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              tgt_q, tgt_d;          // 0 = track A, 1 = track B
    logic [LW-1:0]     len_a_q, len_a_d;
    logic [LW-1:0]     len_b_q, len_b_d;
    logic [SW-1:0]     step_q, step_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [LW-1:0]     plen_q, plen_d;        // playback length, fixed at PLAY entry
    logic [1:0]        sel_q, sel_d;          // track enables, refreshed per step
    logic [NOTE_W-1:0] note_q, note_d;
    logic              done_q, done_d;

    logic [NOTE_W-1:0] buf_a [STEPS];
    logic [NOTE_W-1:0] buf_b [STEPS];
    logic              wr_a, wr_b;

    logic [NOTE_W-1:0] live_note;
    logic [NOTE_W-1:0] note_a, note_b;
    logic              hit_a, hit_b;
    logic [LW-1:0]     en_len_a, en_len_b, play_len;
    logic              tgt_new;

    // Live note is valid only when exactly one key is down; anything else is a rest.
    always_comb begin
        live_note = '0;
        if ((keys != '0) && ((keys & (keys - NOTE_W'(1))) == '0)) begin
            live_note = keys;
        end
    end

    // Per-step track lookups and the playback length seen at PLAY entry.
    always_comb begin
        note_a   = buf_a[step_q];
        note_b   = buf_b[step_q];
        hit_a    = sel_q[0] && ({1'b0, step_q} < len_a_q) && (note_a != '0);
        hit_b    = sel_q[1] && ({1'b0, step_q} < len_b_q) && (note_b != '0);
        en_len_a = play_sel[0] ? len_a_q : '0;
        en_len_b = play_sel[1] ? len_b_q : '0;
        play_len = (en_len_a > en_len_b) ? en_len_a : en_len_b;
    end

    // Next-state logic: mode is sampled every clock and always wins over a strobe.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        len_a_d = len_a_q;
        len_b_d = len_b_q;
        step_d  = step_q;
        tick_d  = tick_q;
        plen_d  = plen_q;
        sel_d   = sel_q;
        done_d  = done_q;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        tgt_new = mode[1];

        case (mode)
            2'b00: begin
                state_d = ST_LIVE;
                done_d  = 1'b0;
                if ((state_q == ST_LIVE) && clear) begin
                    len_a_d = '0;
                    len_b_d = '0;
                end
            end
            2'b01, 2'b10: begin
                done_d = 1'b0;
                if ((state_q != ST_REC) || (tgt_q != tgt_new)) begin
                    state_d = ST_REC;
                    tgt_d   = tgt_new;
                    if (tgt_new) len_b_d = '0;
                    else         len_a_d = '0;
                end else if (step_strobe) begin
                    if (!tgt_q && (len_a_q < LW'(STEPS))) begin
                        wr_a    = 1'b1;
                        len_a_d = len_a_q + LW'(1);
                    end else if (tgt_q && (len_b_q < LW'(STEPS))) begin
                        wr_b    = 1'b1;
                        len_b_d = len_b_q + LW'(1);
                    end
                end
            end
            default: begin
                if ((state_q == ST_LIVE) || (state_q == ST_REC)) begin
                    step_d = '0;
                    tick_d = '0;
                    sel_d  = play_sel;
                    plen_d = play_len;
                    if (play_len == '0) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_PLAY;
                        done_d  = 1'b0;
                    end
                end else if (state_q == ST_PLAY) begin
                    if (tick_q == TW'(TICK_DIV - 1)) begin
                        tick_d = '0;
                        sel_d  = play_sel;
                        if ({1'b0, step_q} == (plen_q - LW'(1))) begin
                            state_d = ST_HOLD;
                            done_d  = 1'b1;
                        end else begin
                            step_d = step_q + SW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
        endcase
    end

    // Output note: live key first, then track A, then track B, else rest.
    always_comb begin
        note_d = '0;
        case (state_q)
            ST_LIVE, ST_REC: note_d = live_note;
            ST_PLAY: begin
                if (live_note != '0) note_d = live_note;
                else if (hit_a)      note_d = note_a;
                else if (hit_b)      note_d = note_b;
            end
            default: note_d = '0;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_LIVE;
            tgt_q   <= 1'b0;
            len_a_q <= '0;
            len_b_q <= '0;
            step_q  <= '0;
            tick_q  <= '0;
            plen_q  <= '0;
            sel_q   <= '0;
            note_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            len_a_q <= len_a_d;
            len_b_q <= len_b_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
            plen_q  <= plen_d;
            sel_q   <= sel_d;
            note_q  <= note_d;
            done_q  <= done_d;
        end
    end

    // Track buffers are not reset; a zero length makes stale contents unreachable.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (wr_a) buf_a[len_a_q[SW-1:0]] <= live_note;
            if (wr_b) buf_b[len_b_q[SW-1:0]] <= live_note;
        end
    end

    assign note_out  = note_q;
    assign len_a     = len_a_q;
    assign len_b     = len_b_q;
    assign play_step = step_q;
    assign done      = done_q;
    assign rec_full  = (state_q == ST_REC) && ((tgt_q ? len_b_q : len_a_q) == LW'(STEPS));

endmodule
